// File: rtl/traceback_prefetch_buffer.sv
// Two-entry ping-pong buffer: captures direction segments from the column finder and streams
// them one direction per handshake to the traceback walker. Optional stats: TB_PREFETCH_STATS_EN.
module traceback_prefetch_buffer #(
    parameter int PL = 8,
    parameter int DW = 3,
    parameter int PW = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PL*DW-1:0]   prefetch_column,
    input  logic               fill_valid,
    output logic               fill_ready,
    input  logic [PW-1:0]      fill_x_start,
    output logic [1:0]         prefetch_request,
    output logic [DW-1:0]      dir_out,
    output logic [PW-1:0]      dir_x,
    output logic               dir_valid,
    output logic               dir_last,
    input  logic               dir_ready,
    input  logic               flush
`ifdef TB_PREFETCH_STATS_EN
    ,
    output logic [15:0]        stall_cycles,
    output logic [15:0]        flush_count
`endif
);
    localparam int IW = (PL > 1) ? $clog2(PL) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(PL - 1);

    logic [PL*DW-1:0] data [2];
    logic [PW-1:0]    xs [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic [IW-1:0]    idx;
    logic             fill_acc;
    logic             pop;
    logic             last_pop;
    logic [PL*DW-1:0] cur_seg;

    assign fill_ready = (count != 2'd2) && !flush;
    assign dir_valid  = (count != 2'd0) && !flush;
    assign dir_last   = dir_valid && (idx == LAST_IDX);
    assign fill_acc   = fill_valid && fill_ready;
    assign pop        = dir_valid && dir_ready;
    assign last_pop   = pop && (idx == LAST_IDX);
    assign cur_seg    = data[rd_ptr];
    assign dir_x      = xs[rd_ptr] + PW'(idx);

    // Element 0 sits in the most significant slice of the segment.
    always_comb begin
        dir_out = '0;
        for (int i = 0; i < PL; i++) begin
            if (idx == IW'(i)) dir_out = cur_seg[(PL-1-i)*DW +: DW];
        end
    end

    always_comb begin
        prefetch_request = 2'b00;
        if (flush) prefetch_request = 2'b01;
        else begin
            case (count)
                2'd0:    prefetch_request = 2'b01;
                2'd1:    prefetch_request = 2'b10;
                default: prefetch_request = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                data[i] <= '0;
                xs[i]   <= '0;
            end
        end else if (fill_acc) begin
            data[wr_ptr] <= prefetch_column;
            xs[wr_ptr]   <= fill_x_start;
        end
    end

    // Flush wins over everything but leaves the stored segments untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            idx    <= '0;
        end else if (flush) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            idx    <= '0;
        end else begin
            if (fill_acc) wr_ptr <= ~wr_ptr;
            if (pop) begin
                if (last_pop) begin
                    idx    <= '0;
                    rd_ptr <= ~rd_ptr;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
            case ({fill_acc, last_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

`ifdef TB_PREFETCH_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (flush && flush_count != 16'hFFFF) flush_count <= flush_count + 16'd1;
            if (!flush && dir_ready && !dir_valid && stall_cycles != 16'hFFFF)
                stall_cycles <= stall_cycles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_traceback_prefetch_buffer.sv
// Scoreboard bench for traceback_prefetch_buffer: accepted segments expand into a queue of
// expected directions that is popped as the walker side consumes them.
module tb_traceback_prefetch_buffer;
    localparam int PL = 8;
    localparam int DW = 3;
    localparam int PW = 10;

    typedef struct {
        logic [DW-1:0] d;
        logic [PW-1:0] x;
        logic          last;
    } elem_t;

    logic               clk;
    logic               rst_n;
    logic [PL*DW-1:0]   prefetch_column;
    logic               fill_valid;
    logic               fill_ready;
    logic [PW-1:0]      fill_x_start;
    logic [1:0]         prefetch_request;
    logic [DW-1:0]      dir_out;
    logic [PW-1:0]      dir_x;
    logic               dir_valid;
    logic               dir_last;
    logic               dir_ready;
    logic               flush;
`ifdef TB_PREFETCH_STATS_EN
    logic [15:0]        stall_cycles;
    logic [15:0]        flush_count;
`endif

    elem_t exp_q[$];
    int    model_count;
    int    model_stalls;
    int    model_flushes;
    int    checks;
    int    errors;
    bit    acc;

    traceback_prefetch_buffer #(.PL(PL), .DW(DW), .PW(PW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .prefetch_column(prefetch_column),
        .fill_valid(fill_valid),
        .fill_ready(fill_ready),
        .fill_x_start(fill_x_start),
        .prefetch_request(prefetch_request),
        .dir_out(dir_out),
        .dir_x(dir_x),
        .dir_valid(dir_valid),
        .dir_last(dir_last),
        .dir_ready(dir_ready),
        .flush(flush)
`ifdef TB_PREFETCH_STATS_EN
        ,
        .stall_cycles(stall_cycles),
        .flush_count(flush_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("[TB] FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare against the model, then advance the model.
    task automatic applyStimulus(input bit fv, input logic [PL*DW-1:0] col, input int xst,
                                 input bit dr, input bit fl, output bit accepted);
        bit m_valid;
        bit m_ready;
        bit popped;
        bit was_last;
        int m_req;
        elem_t e;
        @(negedge clk);
        fill_valid      = fv;
        prefetch_column = col;
        fill_x_start    = PW'(xst);
        dir_ready       = dr;
        flush           = fl;
        #1;
        m_valid = (model_count != 0) && !fl;
        m_ready = (model_count != 2) && !fl;
        m_req   = fl ? 1 : (model_count == 0 ? 1 : (model_count == 1 ? 2 : 0));
        checkOutput("dir_valid", int'(dir_valid), int'(m_valid));
        checkOutput("fill_ready", int'(fill_ready), int'(m_ready));
        checkOutput("prefetch_request", int'(prefetch_request), m_req);
        if (m_valid && exp_q.size() > 0) begin
            checkOutput("dir_out", int'(dir_out), int'(exp_q[0].d));
            checkOutput("dir_x", int'(dir_x), int'(exp_q[0].x));
            checkOutput("dir_last", int'(dir_last), int'(exp_q[0].last));
        end else begin
            checkOutput("dir_last_idle", int'(dir_last), 0);
        end
        accepted = fv && m_ready;
        popped   = m_valid && dr;
        @(posedge clk);
        if (fl) begin
            exp_q.delete();
            model_count = 0;
            model_flushes++;
        end else begin
            if (dr && !m_valid) model_stalls++;
            was_last = 1'b0;
            if (popped) begin
                was_last = exp_q[0].last;
                void'(exp_q.pop_front());
            end
            if (accepted) begin
                for (int i = 0; i < PL; i++) begin
                    e.d    = col[(PL-1-i)*DW +: DW];
                    e.x    = PW'(xst + i);
                    e.last = (i == PL - 1);
                    exp_q.push_back(e);
                end
            end
            model_count = model_count + int'(accepted) - int'(was_last);
        end
    endtask

    function automatic logic [PL*DW-1:0] randCol();
        return PL*DW'($urandom);
    endfunction

    initial begin
        checks = 0; errors = 0; model_count = 0; model_stalls = 0; model_flushes = 0;
        rst_n = 1'b0; fill_valid = 1'b0; prefetch_column = '0; fill_x_start = '0;
        dir_ready = 1'b0; flush = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_dir_valid", int'(dir_valid), 0);
        checkOutput("rst_fill_ready", int'(fill_ready), 1);
        checkOutput("rst_prefetch_request", int'(prefetch_request), 1);
        checkOutput("rst_dir_out", int'(dir_out), 0);
        checkOutput("rst_dir_x", int'(dir_x), 0);
        checkOutput("rst_dir_last", int'(dir_last), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) applyStimulus(1'b0, '0, 0, 1'b0, 1'b0, acc);

        // Single segment 1..7,0 at x=100, walker always ready
        applyStimulus(1'b1, 24'o12345670, 100, 1'b1, 1'b0, acc);
        checkOutput("fill_a_accept", int'(acc), 1);
        repeat (10) applyStimulus(1'b0, '0, 0, 1'b1, 1'b0, acc);

        // Two back-to-back fills while stalled, then a held third fill
        applyStimulus(1'b1, randCol(), 300, 1'b0, 1'b0, acc);
        applyStimulus(1'b1, randCol(), 400, 1'b0, 1'b0, acc);
        applyStimulus(1'b0, '0, 0, 1'b0, 1'b0, acc);
        begin
            logic [PL*DW-1:0] col_d;
            bit got;
            col_d = randCol();
            got = 1'b0;
            for (int k = 0; k < 40 && !got; k++) applyStimulus(1'b1, col_d, 500, 1'b1, 1'b0, got);
            checkOutput("held_fill_accept", int'(got), 1);
        end
        repeat (20) applyStimulus(1'b0, '0, 0, 1'b1, 1'b0, acc);

        // Fill coinciding with the last pop at count 1
        applyStimulus(1'b1, randCol(), 600, 1'b1, 1'b0, acc);
        repeat (7) applyStimulus(1'b0, '0, 0, 1'b1, 1'b0, acc);
        applyStimulus(1'b1, randCol(), 700, 1'b1, 1'b0, acc);
        checkOutput("same_cycle_accept", int'(acc), 1);
        checkOutput("same_cycle_count", model_count, 1);
        repeat (10) applyStimulus(1'b0, '0, 0, 1'b1, 1'b0, acc);

        // Flush at idx 3 alongside a fill, then restart from x=200
        applyStimulus(1'b1, randCol(), 800, 1'b1, 1'b0, acc);
        repeat (3) applyStimulus(1'b0, '0, 0, 1'b1, 1'b0, acc);
        applyStimulus(1'b1, randCol(), 900, 1'b1, 1'b1, acc);
        repeat (2) applyStimulus(1'b0, '0, 0, 1'b1, 1'b0, acc);
        applyStimulus(1'b1, randCol(), 200, 1'b1, 1'b0, acc);
        repeat (10) applyStimulus(1'b0, '0, 0, 1'b1, 1'b0, acc);

        // x coordinate wrap-around
        applyStimulus(1'b1, randCol(), 1020, 1'b1, 1'b0, acc);
        repeat (10) applyStimulus(1'b0, '0, 0, 1'b1, 1'b0, acc);

`ifdef TB_PREFETCH_STATS_EN
        #1;
        checkOutput("stall_cycles", int'(stall_cycles), model_stalls);
        checkOutput("flush_count", int'(flush_count), model_flushes);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/traceback_prefetch_buffer.md
Name: traceback_prefetch_buffer

Overview:
- Two-entry ping-pong buffer directly downstream of the traceback prefetch column finder.
- Captures PREFETCH_LENGTH-element direction segments (prefetch_column) and streams them one direction per handshake to the traceback walker.
- Drives prefetch_request back to the finder: current segment when empty, next segment when half full, nothing when full.
- Hides direction-memory latency so the walker consumes one direction per cycle while the next segment is being fetched.

Parameters:
- PL, 8, directions per segment (equals `PREFETCH_LENGTH).
- DW, 3, bits per direction (equals `DIRECTION_WIDTH).
- PW, 10, x-position width (equals `POSITION_WIDTH).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- prefetch_column  in  PL*DW  segment from finder; element i occupies bits [i*DW : i*DW+DW-1] in ascending [0:PL*DW-1] numbering, so element 0 is the MSB slice.
- fill_valid  in  1  prefetch_column and fill_x_start are valid this cycle.
- fill_ready  out  1  buffer can accept a segment.
- fill_x_start  in  PW  x coordinate of element 0 of the segment.
- prefetch_request  out  2  01 = fetch current, 10 = fetch next, 00 = idle.
- dir_out  out  DW  current direction.
- dir_x  out  PW  x coordinate of dir_out (fill_x_start + index, modulo 2^PW).
- dir_valid  out  1  dir_out is valid.
- dir_last  out  1  dir_out is the final element of its segment.
- dir_ready  in  1  walker accepts dir_out.
- flush  in  1  walker changed column; discard all buffered data.

Behaviour:
- State:
  - entry data[2] of PL*DW bits; tag xs[2] of PW bits.
  - wr_ptr and rd_ptr, 1 bit each.
  - count, 2 bits, legal values 0..2.
  - idx, element index, ceil(log2 PL) bits.
- Reset (async, rst_n low): count=0, wr_ptr=0, rd_ptr=0, idx=0, entry storage cleared to 0.
  - Resulting outputs: dir_valid=0, dir_last=0, dir_out=0, dir_x=0, fill_ready=1, prefetch_request=01.
  - Reset asserted mid-stream discards all data immediately.
- fill_ready = (count!=2) and not flush.
  - No write-through bypass.
  - A segment accepted at edge t is visible on dir_out no earlier than the cycle after t (1-cycle fill-to-output latency).
- Fill accepted when fill_valid and fill_ready: data[wr_ptr] and xs[wr_ptr] are written, wr_ptr toggles, count increments.
- dir_valid = (count!=0) and not flush.
- dir_out = element idx of data[rd_ptr], combinational from registers.
- dir_x = xs[rd_ptr] + idx.
- dir_last = dir_valid and (idx==PL-1).
- Pop occurs when dir_valid and dir_ready.
  - idx increments.
  - If idx==PL-1: idx returns to 0, rd_ptr toggles, count decrements.
- Fill and last-element pop in the same cycle: count is unchanged and both pointers advance. This case is only possible at count==1, because fill_ready is 0 at count==2.
- prefetch_request is a combinational function of registered count:
  - count 0 → 01
  - count 1 → 10
  - count 2 → 00
  - flush high → 01
- Flush (synchronous, highest priority):
  - count=0, wr_ptr=0, rd_ptr=0, idx=0.
  - Any fill or pop in the same cycle is ignored.
  - Storage contents are not cleared.
- dir_valid stays low while the walker holds flush. The next accepted fill after flush is the first segment streamed.
- fill_valid while fill_ready is low is dropped. The finder must hold fill_valid until it sees fill_ready.
- dir_x wraps modulo 2^PW with no saturation.

Optional Feature:
- Macro: TB_PREFETCH_STATS_EN.
- With the macro defined:
  - Adds output stall_cycles[15:0], which increments on every cycle with dir_ready=1 and dir_valid=0, outside flush.
  - Adds output flush_count[15:0], which increments on each flush cycle.
  - Both counters saturate at 16'hFFFF and reset to 0 on rst_n.
- Without the macro: neither port nor any counter logic exists, and all other behaviour is identical.

Test Plan:
- Reset, then idle → dir_valid=0, fill_ready=1, prefetch_request=01, dir_out=0.
- Fill one segment: prefetch_column elements 0..7 = 1,2,3,4,5,6,7,0 and fill_x_start=100, with dir_ready held 1 → from the next cycle, 8 consecutive pops give dir_out 1..7,0 and dir_x 100..107. dir_last is high only on the 8th pop. prefetch_request=10 throughout, then 01 after the last pop.
- Two back-to-back fills with dir_ready=0 → count=2, fill_ready=0, prefetch_request=00. A third fill_valid is held until the first segment's last pop, then accepted, with no gap in dir_valid.
- count=1 with idx=7, fill_valid and pop in the same cycle → count stays 1, dir_out switches to element 0 of the new segment, and dir_x equals the new segment's fill_x_start.
- Flush asserted at idx=3 together with fill_valid=1 → next cycle count=0, dir_valid=0, prefetch_request=01. The fill is ignored. A subsequent fill with x_start=200 streams from dir_x=200.
- fill_x_start=1020 with PW=10 → dir_x sequence 1020..1023, 0, 1, 2, 3 (wrap-around).
